// File: rtl/host_line_port.sv
// host_line_port: host end of the MCU byte link.
// Streams a line out to the mcu byte by byte and assembles returned bytes into a line.
module host_line_port #(
   parameter int unsigned num_bits = 512,
   parameter int unsigned rd_lat   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [num_bits-1:0] tx_line,
   input  logic                tx_start,
   input  logic                rx_start,
   output logic [7:0]          host_input,
   output logic                line_read_from_host_en,
   output logic                line_write_to_host_en,
   input  logic [7:0]          bram_to_host,
   input  logic                done_flag,
   output logic [num_bits-1:0] rx_line,
   output logic                rx_valid,
   output logic                tx_done,
   output logic                busy,
   output logic                err
);

   localparam int unsigned NB = num_bits / 8;
   localparam int unsigned CW = $clog2(NB) + 1;
   localparam logic [CW-1:0] LAST = CW'(NB - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_TX    = 2'd1;
   localparam logic [1:0] S_RX    = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]          state, state_nxt;
   logic [CW-1:0]       idx, idx_nxt, idx_inc;
   logic [CW-1:0]       req, req_nxt;
   logic [CW-1:0]       cap, cap_nxt;
   logic [num_bits-1:0] shadow, shadow_nxt;
   logic [num_bits-1:0] rx_line_nxt;
   logic [7:0]          host_input_nxt;
   logic                rd_en_nxt, wr_en_nxt, rx_valid_nxt, tx_done_nxt, busy_nxt, err_nxt;
   logic [CW+1:0]       tx_sh, rx_sh;
   logic                cap_pend, cap_fire, last_cap;

   assign idx_inc  = idx + CW'(1);
   assign tx_sh    = {idx_inc[CW-2:0], 3'b000};
   assign rx_sh    = {cap[CW-2:0], 3'b000};
   assign cap_fire = ((state == S_RX) || (state == S_DRAIN)) && cap_pend;
   assign last_cap = cap_fire && (cap == LAST);

   // Request k becomes a capture rd_lat cycles later; requests are strictly in order.
   generate
      if (rd_lat == 0) begin : g_lat0
         assign cap_pend = (state == S_RX);
      end else begin : g_latn
         logic [rd_lat-1:0] req_pipe;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)                  req_pipe <= '0;
            else if (state == S_IDLE) req_pipe <= '0;
            else                      req_pipe <= rd_lat'({req_pipe, state == S_RX});
         end
         assign cap_pend = req_pipe[rd_lat-1];
      end
   endgenerate

   // Next-state and next-output logic.
   always_comb begin
      state_nxt      = state;
      idx_nxt        = idx;
      req_nxt        = req;
      cap_nxt        = cap;
      shadow_nxt     = shadow;
      rx_line_nxt    = rx_line;
      host_input_nxt = host_input;
      rd_en_nxt      = 1'b0;
      wr_en_nxt      = 1'b0;
      rx_valid_nxt   = 1'b0;
      tx_done_nxt    = 1'b0;
      err_nxt        = err;

      if (cap_fire) begin
         rx_line_nxt = (rx_line & ~(num_bits'(8'hFF) << rx_sh))
                     | (num_bits'(bram_to_host) << rx_sh);
         if (cap != LAST) cap_nxt = cap + CW'(1);
      end

      case (state)
         S_IDLE: begin
            if (tx_start) begin
               state_nxt      = S_TX;
               shadow_nxt     = tx_line;
               idx_nxt        = '0;
               host_input_nxt = tx_line[7:0];
               rd_en_nxt      = 1'b1;
               err_nxt        = 1'b0;
            end else if (rx_start) begin
               state_nxt   = S_RX;
               rx_line_nxt = '0;
               req_nxt     = '0;
               cap_nxt     = '0;
               wr_en_nxt   = 1'b1;
               err_nxt     = 1'b0;
            end
         end
         S_TX: begin
            // A late done_flag on the final byte is tolerated.
            if (done_flag && (idx != LAST)) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else if (idx == LAST) begin
               state_nxt   = S_IDLE;
               tx_done_nxt = 1'b1;
            end else begin
               idx_nxt        = idx_inc;
               host_input_nxt = 8'(shadow >> tx_sh);
               rd_en_nxt      = 1'b1;
            end
         end
         S_RX: begin
            if (last_cap) begin
               state_nxt    = S_IDLE;
               rx_valid_nxt = 1'b1;
            end else if (done_flag) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else if (req == LAST) begin
               state_nxt = S_DRAIN;
            end else begin
               req_nxt   = req + CW'(1);
               wr_en_nxt = 1'b1;
            end
         end
         default: begin
            if (last_cap) begin
               state_nxt    = S_IDLE;
               rx_valid_nxt = 1'b1;
            end else if (done_flag) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                  <= S_IDLE;
         idx                    <= '0;
         req                    <= '0;
         cap                    <= '0;
         shadow                 <= '0;
         rx_line                <= '0;
         host_input             <= '0;
         line_read_from_host_en <= 1'b0;
         line_write_to_host_en  <= 1'b0;
         rx_valid               <= 1'b0;
         tx_done                <= 1'b0;
         busy                   <= 1'b0;
         err                    <= 1'b0;
      end else begin
         state                  <= state_nxt;
         idx                    <= idx_nxt;
         req                    <= req_nxt;
         cap                    <= cap_nxt;
         shadow                 <= shadow_nxt;
         rx_line                <= rx_line_nxt;
         host_input             <= host_input_nxt;
         line_read_from_host_en <= rd_en_nxt;
         line_write_to_host_en  <= wr_en_nxt;
         rx_valid               <= rx_valid_nxt;
         tx_done                <= tx_done_nxt;
         busy                   <= busy_nxt;
         err                    <= err_nxt;
      end
   end

endmodule

// File: tb/tb_host_line_port.sv
// tb_host_line_port: scoreboard bench for host_line_port with a one-cycle-latency mcu model.
module tb_host_line_port;

   localparam int unsigned NUM_BITS = 512;
   localparam int unsigned NB       = NUM_BITS / 8;
   localparam int unsigned W        = NUM_BITS;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [W-1:0]    tx_line = '0;
   logic            tx_start = 1'b0;
   logic            rx_start = 1'b0;
   logic [7:0]      host_input;
   logic            line_read_from_host_en;
   logic            line_write_to_host_en;
   logic [7:0]      bram_to_host = 8'hEE;
   logic            done_flag = 1'b0;
   logic [W-1:0]    rx_line;
   logic            rx_valid;
   logic            tx_done;
   logic            busy;
   logic            err;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]   tx_q[$];
   logic [W-1:0] rx_q[$];

   bit have_req = 1'b0;
   int req_k = 0;
   int model_cnt = 0;
   int mul = 1;
   int add = 1;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int txd_cnt = 0;
   int rxv_cnt = 0;

   host_line_port #(.num_bits(NUM_BITS), .rd_lat(1)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .tx_line                (tx_line),
      .tx_start               (tx_start),
      .rx_start               (rx_start),
      .host_input             (host_input),
      .line_read_from_host_en (line_read_from_host_en),
      .line_write_to_host_en  (line_write_to_host_en),
      .bram_to_host           (bram_to_host),
      .done_flag              (done_flag),
      .rx_line                (rx_line),
      .rx_valid               (rx_valid),
      .tx_done                (tx_done),
      .busy                   (busy),
      .err                    (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: mcu model answers request k with byte (k*mul+add) one cycle later; scoreboard pops.
   task automatic tick();
      @(posedge clk);
      #1;
      bram_to_host = have_req ? 8'(req_k * mul + add) : 8'hEE;
      have_req = line_write_to_host_en;
      if (have_req) begin
         req_k = model_cnt;
         model_cnt++;
      end
      if (line_read_from_host_en) begin
         rd_cnt++;
         if (tx_q.size() != 0) check("tx_byte", W'(host_input), W'(tx_q.pop_front()));
         else                  check("tx_spurious", W'(line_read_from_host_en), '0);
      end
      if (line_write_to_host_en) wr_cnt++;
      if (tx_done) txd_cnt++;
      if (rx_valid) begin
         rxv_cnt++;
         if (rx_q.size() != 0) check("rx_line", rx_line, rx_q.pop_front());
         else                  check("rx_spurious", W'(rx_valid), '0);
      end
   endtask

   function automatic logic [W-1:0] rand_line();
      logic [W-1:0] l;
      for (int i = 0; i < int'(W / 32); i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   task automatic run_tx(input logic [W-1:0] line, input bit late_done, input bit also_rx);
      int n;
      int rd0, td0, wr0;
      for (int i = 0; i < int'(NB); i++) tx_q.push_back(line[8*i +: 8]);
      rd0 = rd_cnt; td0 = txd_cnt; wr0 = wr_cnt;
      tx_line  = line;
      tx_start = 1'b1;
      rx_start = also_rx;
      tick();
      tx_start = 1'b0;
      rx_start = 1'b0;
      check("tx_err_clr", W'(err), '0);
      n = 1;
      while (!tx_done && n < 200) begin
         done_flag = late_done && (n == int'(NB));
         rx_start  = also_rx && (n == 20);
         tick();
         n++;
      end
      done_flag = 1'b0;
      rx_start  = 1'b0;
      check("tx_done_lat", W'(n), W'(NB + 1));
      check("tx_en_cycles", W'(rd_cnt - rd0), W'(NB));
      check("tx_done_cnt", W'(txd_cnt - td0), W'(1));
      check("tx_no_wr", W'(wr_cnt - wr0), '0);
      check("tx_err", W'(err), '0);
      check("txq_empty", W'(tx_q.size()), '0);
      repeat (3) tick();
      check("tx_idle_busy", W'(busy), '0);
      check("tx_idle_wr", W'(wr_cnt - wr0), '0);
   endtask

   task automatic run_rx(input int m, input int a);
      logic [W-1:0] e;
      int n;
      int wr0, rv0;
      mul = m; add = a; model_cnt = 0;
      for (int k = 0; k < int'(NB); k++) e[8*k +: 8] = 8'(k * m + a);
      rx_q.push_back(e);
      wr0 = wr_cnt; rv0 = rxv_cnt;
      rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
      check("rx_err_clr", W'(err), '0);
      check("rx_busy", W'(busy), W'(1));
      n = 1;
      while (!rx_valid && n < 300) begin
         tick();
         n++;
      end
      check("rx_lat", W'(n), W'(NB + 2));
      check("rx_wr_cycles", W'(wr_cnt - wr0), W'(NB));
      check("rx_valid_cnt", W'(rxv_cnt - rv0), W'(1));
      check("rx_err", W'(err), '0);
      check("rxq_empty", W'(rx_q.size()), '0);
      tick();
      check("rx_valid_pulse", W'(rx_valid), '0);
      check("rx_idle_busy", W'(busy), '0);
   endtask

   initial begin
      logic [W-1:0] line;
      int rv0, td0;

      // Reset state
      #8;
      check("rst_host_input", W'(host_input), '0);
      check("rst_rd_en", W'(line_read_from_host_en), '0);
      check("rst_wr_en", W'(line_write_to_host_en), '0);
      check("rst_rx_line", rx_line, '0);
      check("rst_rx_valid", W'(rx_valid), '0);
      check("rst_tx_done", W'(tx_done), '0);
      check("rst_busy", W'(busy), '0);
      check("rst_err", W'(err), '0);
      #2;
      rst = 1'b0;

      // Full TX of the A5 ^ index pattern
      for (int i = 0; i < int'(NB); i++) line[8*i +: 8] = 8'hA5 ^ 8'(i);
      run_tx(line, 1'b0, 1'b0);

      // Full RX, byte k = k+1
      run_rx(1, 1);
      check("rx_byte0", W'(rx_line[7:0]), W'(8'h01));
      check("rx_byte63", W'(rx_line[W-1 -: 8]), W'(8'h40));

      // done_flag during TX byte 10 aborts with err
      line = rand_line();
      for (int i = 0; i <= 10; i++) tx_q.push_back(line[8*i +: 8]);
      td0 = txd_cnt;
      tx_line = line;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      repeat (10) tick();
      done_flag = 1'b1;
      tick();
      done_flag = 1'b0;
      check("txab_err", W'(err), W'(1));
      check("txab_busy", W'(busy), '0);
      check("txab_rd_en", W'(line_read_from_host_en), '0);
      repeat (5) tick();
      check("txab_no_done", W'(txd_cnt - td0), '0);
      check("txab_q_empty", W'(tx_q.size()), '0);
      check("txab_err_sticky", W'(err), W'(1));
      // Next TX clears err; done_flag on the last byte is tolerated
      run_tx(rand_line(), 1'b1, 1'b0);

      // Simultaneous starts favour TX; rx_start during TX ignored
      run_tx(rand_line(), 1'b0, 1'b1);

      // Reset in the middle of RX
      rv0 = rxv_cnt;
      mul = 2; add = 3; model_cnt = 0;
      rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
      repeat (20) tick();
      rst = 1'b1;
      #1;
      check("rxrst_wr_en", W'(line_write_to_host_en), '0);
      check("rxrst_busy", W'(busy), '0);
      check("rxrst_rx_line", rx_line, '0);
      have_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (80) tick();
      check("rxrst_no_valid", W'(rxv_cnt - rv0), '0);
      check("rxrst_idle", W'(busy), '0);
      run_rx(5, 9);

      // done_flag early in RX aborts with err
      rv0 = rxv_cnt;
      mul = 1; add = 0; model_cnt = 0;
      rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
      repeat (5) tick();
      done_flag = 1'b1;
      tick();
      done_flag = 1'b0;
      check("rxab_err", W'(err), W'(1));
      check("rxab_busy", W'(busy), '0);
      check("rxab_wr_en", W'(line_write_to_host_en), '0);
      repeat (5) tick();
      check("rxab_no_valid", W'(rxv_cnt - rv0), '0);
      run_rx(3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
